// File: rtl/sap1_pkg.sv
// Shared SAP-1 types and constants: sequencer states, default widths and opcodes.
package sap1_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OPC_W_DEF  = 4;

  localparam logic [3:0] OpcLda = 4'h0;
  localparam logic [3:0] OpcAdd = 4'h1;
  localparam logic [3:0] OpcSub = 4'h2;
  localparam logic [3:0] OpcOut = 4'hE;
  localparam logic [3:0] OpcHlt = 4'hF;

  typedef enum logic [3:0] {
    StIdle,
    StFAddr,
    StFStrb,
    StFLatch,
    StExec,
    StDAddr,
    StDStrb,
    StDLatch,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// Program counter with synchronous load, increment (wrapping) and async reset.
module program_counter
  import sap1_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else if (load_i) begin
      pc_q <= load_val_i;
    end else if (inc_i) begin
      // Natural overflow gives the 15 -> 0 wrap.
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// SAP-1 fetch / operand-access sequencer: owns PC, MAR and IR, strobes the RAM
// with an active-low read and returns instruction or operand bytes.
module fetch_unit
  import sap1_pkg::*;
#(
  parameter int unsigned       ADDR_W  = ADDR_W_DEF,
  parameter int unsigned       DATA_W  = DATA_W_DEF,
  parameter int unsigned       OPC_W   = OPC_W_DEF,
  parameter logic [OPC_W-1:0]  HLT_OPC = OPC_W'(OpcHlt)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              cen_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] ir_o,
  output logic              ir_valid_o,
  input  logic              next_i,
  input  logic              jmp_i,
  input  logic [ADDR_W-1:0] jmp_addr_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cen_q;
  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              halted_q;

  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;

  // Jump has top priority in EXEC, so the PC load only depends on jmp_i there.
  always_comb begin
    pc_load = (state_q == StExec) && jmp_i;
    pc_inc  = (state_q == StFStrb);
  end

  program_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (pc_load),
    .load_val_i (jmp_addr_i),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cen_q      <= 1'b1;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run_i) begin
            addr_q  <= pc;
            state_q <= StFAddr;
          end
        end
        StFAddr: begin
          cen_q   <= 1'b0;
          state_q <= StFStrb;
        end
        StFStrb: begin
          cen_q   <= 1'b1;
          state_q <= StFLatch;
        end
        StFLatch: begin
          ir_q <= mem_data_i;
          if (mem_data_i[DATA_W-1 -: OPC_W] == HLT_OPC) begin
            halted_q <= 1'b1;
            state_q  <= StHalt;
          end else begin
            ir_valid_q <= 1'b1;
            state_q    <= StExec;
          end
        end
        StExec: begin
          if (jmp_i) begin
            addr_q     <= jmp_addr_i;
            ir_valid_q <= 1'b0;
            state_q    <= StFAddr;
          end else if (rd_req_i) begin
            addr_q     <= rd_addr_i;
            ir_valid_q <= 1'b0;
            state_q    <= StDAddr;
          end else if (next_i) begin
            addr_q     <= pc;
            ir_valid_q <= 1'b0;
            state_q    <= StFAddr;
          end
        end
        StDAddr: begin
          cen_q   <= 1'b0;
          state_q <= StDStrb;
        end
        StDStrb: begin
          cen_q   <= 1'b1;
          state_q <= StDLatch;
        end
        StDLatch: begin
          rd_data_q  <= mem_data_i;
          rd_valid_q <= 1'b1;
          ir_valid_q <= 1'b1;
          state_q    <= StExec;
        end
        StHalt: begin
          cen_q    <= 1'b1;
          halted_q <= 1'b1;
        end
        default: begin
          cen_q   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign addr_o     = addr_q;
  assign cen_o      = cen_q;
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign pc_o       = pc;
  assign halted_o   = halted_q;

endmodule
